// File: rtl/nanosoc_busmatrix_default_slave_log.sv
// rtl/nanosoc_busmatrix_default_slave_log.sv - bus matrix default slave with unmapped-access log
//
// Purpose: answers transfers that hit no real slave with WAIT_STATES wait
// cycles followed by either a two-cycle ERROR (RESP_MODE=0) or a single
// OKAY cycle with read-as-zero (RESP_MODE=1). The first unmapped access is
// captured, later ones only set an overflow flag, and every access bumps a
// saturating counter. IRQ is a level signal to system control.
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   HSEL, HTRANS, HREADY  address-phase qualifiers from the decoder/bus
//   HADDR, HWRITE, HSIZE  address-phase attributes (logged)
//   HMASTER               master ID (logged)
//   HREADYOUT, HRESP      registered response, HRDATA tied to zero
//   LOG_CLR, IRQ_EN       log clear pulse, interrupt enable
//   LOG_*                 captured access, sticky flags, saturating count
//   IRQ                   LOG_VALID & IRQ_EN
module nanosoc_busmatrix_default_slave_log #(
  parameter int ADDR_WIDTH   = 32,
  parameter int MASTER_WIDTH = 4,
  parameter int WAIT_STATES  = 0,
  parameter int RESP_MODE    = 0,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [1:0]              HTRANS,
  input  logic                    HREADY,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [MASTER_WIDTH-1:0] HMASTER,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [31:0]             HRDATA,
  input  logic                    LOG_CLR,
  input  logic                    IRQ_EN,
  output logic                    LOG_VALID,
  output logic                    LOG_OVF,
  output logic [ADDR_WIDTH-1:0]   LOG_ADDR,
  output logic                    LOG_WRITE,
  output logic [2:0]              LOG_SIZE,
  output logic [MASTER_WIDTH-1:0] LOG_MASTER,
  output logic [CNT_WIDTH-1:0]    LOG_CNT,
  output logic                    IRQ
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t     state_q;
  state_t     state_d;
  state_t     resp_state;
  logic [3:0] wcnt_q;
  logic [3:0] wcnt_d;
  logic       hreadyout_d;
  logic       hresp_d;
  logic       can_accept;
  logic       accept;

  // WAIT and ERR1 hold HREADY low on the bus, so address phases presented
  // there are not real; only the ready states may take a new transfer.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_ERR2) || (state_q == S_DONE);
  assign accept     = HSEL & HREADY & HTRANS[1] & can_accept;
  assign resp_state = (RESP_MODE == 0) ? S_ERR1 : S_DONE;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = resp_state;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = resp_state;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    // Response outputs are decoded from the next state and registered so
    // they leave the flops cleanly together with the state.
    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      wcnt_q    <= 4'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
    end
  end

  assign HRDATA = 32'd0;

  // Clear is applied first; a simultaneous accept then records into the
  // freshly cleared log (later non-blocking assignments take precedence).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      LOG_VALID  <= 1'b0;
      LOG_OVF    <= 1'b0;
      LOG_ADDR   <= '0;
      LOG_WRITE  <= 1'b0;
      LOG_SIZE   <= 3'd0;
      LOG_MASTER <= '0;
      LOG_CNT    <= '0;
    end else begin
      if (LOG_CLR) begin
        LOG_VALID <= 1'b0;
        LOG_OVF   <= 1'b0;
        LOG_CNT   <= '0;
      end
      if (accept) begin
        if (LOG_CLR || !LOG_VALID) begin
          LOG_VALID  <= 1'b1;
          LOG_ADDR   <= HADDR;
          LOG_WRITE  <= HWRITE;
          LOG_SIZE   <= HSIZE;
          LOG_MASTER <= HMASTER;
        end else begin
          LOG_OVF <= 1'b1;
        end
        if (LOG_CLR) begin
          LOG_CNT <= CNT_WIDTH'(1);
        end else if (LOG_CNT != {CNT_WIDTH{1'b1}}) begin
          LOG_CNT <= LOG_CNT + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign IRQ = LOG_VALID & IRQ_EN;

endmodule

// File: tb/tb_nanosoc_busmatrix_default_slave_log.sv
// tb/tb_nanosoc_busmatrix_default_slave_log.sv - self-checking bench for the default slave log
module tb_nanosoc_busmatrix_default_slave_log;

  localparam int NI = 3;
  localparam int WS_P [NI] = '{0, 3, 2};
  localparam int RM_P [NI] = '{0, 0, 1};
  localparam int CW_P [NI] = '{8, 2, 8};

  typedef struct packed {
    logic [1:0]  htrans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [3:0]  master;
    logic        clr;
  } xfer_t;

  logic        clk;
  logic        hresetn;
  logic        hsel;
  int          sel;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hmaster;
  logic        log_clr;
  logic        irq_en;

  logic        o_rdy    [NI];
  logic        o_rsp    [NI];
  logic [31:0] o_rdata  [NI];
  logic        o_valid  [NI];
  logic        o_ovf    [NI];
  logic [31:0] o_addr   [NI];
  logic        o_write  [NI];
  logic [2:0]  o_size   [NI];
  logic [3:0]  o_master [NI];
  logic [7:0]  o_cnt    [NI];
  logic        o_irq    [NI];

  int n_cmp;
  int n_fail;

  // Reference log: number of accesses since the last clear plus the first capture.
  int          m_n      [NI];
  logic [31:0] m_addr   [NI];
  logic        m_write  [NI];
  logic [2:0]  m_size   [NI];
  logic [3:0]  m_master [NI];

  xfer_t bq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CW_P[g]-1:0] cnt_w;
    nanosoc_busmatrix_default_slave_log #(
      .ADDR_WIDTH(32), .MASTER_WIDTH(4), .WAIT_STATES(WS_P[g]),
      .RESP_MODE(RM_P[g]), .CNT_WIDTH(CW_P[g])
    ) u_dut (
      .HCLK(clk), .HRESETn(hresetn),
      .HSEL(hsel && (sel == g)), .HTRANS(htrans), .HREADY(o_rdy[g]),
      .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize), .HMASTER(hmaster),
      .HREADYOUT(o_rdy[g]), .HRESP(o_rsp[g]), .HRDATA(o_rdata[g]),
      .LOG_CLR(log_clr && (sel == g)), .IRQ_EN(irq_en),
      .LOG_VALID(o_valid[g]), .LOG_OVF(o_ovf[g]), .LOG_ADDR(o_addr[g]),
      .LOG_WRITE(o_write[g]), .LOG_SIZE(o_size[g]), .LOG_MASTER(o_master[g]),
      .LOG_CNT(cnt_w), .IRQ(o_irq[g])
    );
    assign o_cnt[g] = 8'(cnt_w);
  end

  function automatic xfer_t mk(input logic [1:0] t, input logic [31:0] a, input logic w,
                               input logic [3:0] m, input logic c);
    xfer_t x;
    x.htrans = t; x.addr = a; x.write = w; x.size = 3'd2; x.master = m; x.clr = c;
    return x;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t x;
    x.htrans = 2'($urandom_range(0, 3));
    x.addr   = $urandom;
    x.write  = 1'($urandom_range(0, 1));
    x.size   = 3'($urandom_range(0, 7));
    x.master = 4'($urandom_range(0, 15));
    x.clr    = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  task automatic drive(input xfer_t x);
    htrans = x.htrans; haddr = x.addr; hwrite = x.write;
    hsize = x.size; hmaster = x.master; log_clr = x.clr;
  endtask

  task automatic drive_idle();
    htrans = 2'b00; log_clr = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_n[i] = 0; m_addr[i] = '0; m_write[i] = 1'b0; m_size[i] = '0; m_master[i] = '0;
    end
  endtask

  // Plays the queued transfers back-to-back on one instance and checks every
  // data-phase cycle plus the log state right after each address phase.
  task automatic run_burst(input int inst);
    xfer_t cur;
    int    len, tout, cmax, ecnt, ws;
    logic  er, ea;
    ws = WS_P[inst];
    cmax = (1 << CW_P[inst]) - 1;
    tout = 0;
    while (o_rdy[inst] !== 1'b1 && tout < 50) begin
      @(negedge clk);
      tout++;
    end
    n_cmp++;
    if (tout >= 50) begin
      n_fail++;
      $display("FAIL idle_wait inst%0d: HREADYOUT stuck at %b, want 1", inst, o_rdy[inst]);
    end
    @(posedge clk); #1;
    sel = inst;
    drive(bq[0]);
    while (bq.size() > 0) begin
      cur = bq.pop_front();
      @(posedge clk);
      if (cur.clr) m_n[inst] = 0;
      if (cur.htrans[1]) begin
        if (m_n[inst] == 0) begin
          m_addr[inst] = cur.addr; m_write[inst] = cur.write;
          m_size[inst] = cur.size; m_master[inst] = cur.master;
        end
        m_n[inst]++;
      end
      len = !cur.htrans[1] ? 1 : (RM_P[inst] != 0 ? ws + 1 : ws + 2);
      for (int j = 0; j < len; j++) begin
        if (j > 0) @(posedge clk);
        #1;
        if (j == len - 1 && bq.size() > 0) drive(bq[0]);
        else drive_idle();
        if (!cur.htrans[1]) begin er = 1'b1; ea = 1'b0; end
        else if (j < ws)    begin er = 1'b0; ea = 1'b0; end
        else if (RM_P[inst] != 0) begin er = 1'b1; ea = 1'b0; end
        else if (j == ws)   begin er = 1'b0; ea = 1'b1; end
        else                begin er = 1'b1; ea = 1'b1; end
        @(negedge clk);
        n_cmp += 3;
        if (o_rdy[inst] !== er) begin
          n_fail++;
          $display("FAIL hreadyout inst%0d a=%h cyc%0d: got %b want %b", inst, cur.addr, j, o_rdy[inst], er);
        end
        if (o_rsp[inst] !== ea) begin
          n_fail++;
          $display("FAIL hresp inst%0d a=%h cyc%0d: got %b want %b", inst, cur.addr, j, o_rsp[inst], ea);
        end
        if (o_rdata[inst] !== 32'd0) begin
          n_fail++;
          $display("FAIL hrdata inst%0d cyc%0d: got %h want 0", inst, j, o_rdata[inst]);
        end
        if (j == 0) begin
          ecnt = (m_n[inst] > cmax) ? cmax : m_n[inst];
          n_cmp += 8;
          if (o_valid[inst] !== (m_n[inst] > 0)) begin
            n_fail++; $display("FAIL log_valid inst%0d: got %b want %b", inst, o_valid[inst], m_n[inst] > 0);
          end
          if (o_ovf[inst] !== (m_n[inst] > 1)) begin
            n_fail++; $display("FAIL log_ovf inst%0d: got %b want %b", inst, o_ovf[inst], m_n[inst] > 1);
          end
          if (o_cnt[inst] !== 8'(ecnt)) begin
            n_fail++; $display("FAIL log_cnt inst%0d: got %0d want %0d", inst, o_cnt[inst], ecnt);
          end
          if (o_addr[inst] !== m_addr[inst]) begin
            n_fail++; $display("FAIL log_addr inst%0d: got %h want %h", inst, o_addr[inst], m_addr[inst]);
          end
          if (o_write[inst] !== m_write[inst]) begin
            n_fail++; $display("FAIL log_write inst%0d: got %b want %b", inst, o_write[inst], m_write[inst]);
          end
          if (o_size[inst] !== m_size[inst]) begin
            n_fail++; $display("FAIL log_size inst%0d: got %0d want %0d", inst, o_size[inst], m_size[inst]);
          end
          if (o_master[inst] !== m_master[inst]) begin
            n_fail++; $display("FAIL log_master inst%0d: got %0d want %0d", inst, o_master[inst], m_master[inst]);
          end
          if (o_irq[inst] !== ((m_n[inst] > 0) && irq_en)) begin
            n_fail++; $display("FAIL irq inst%0d: got %b want %b", inst, o_irq[inst], (m_n[inst] > 0) && irq_en);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0; hsel = 1'b1; sel = 0; irq_en = 1'b1;
    htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = '0; hmaster = '0; log_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_cmp += 5;
      if (o_rdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_rdy inst%0d: got %b want 1", i, o_rdy[i]); end
      if (o_rsp[i] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp inst%0d: got %b want 0", i, o_rsp[i]); end
      if (o_valid[i] !== 1'b0 || o_ovf[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_flags inst%0d: got %b%b want 00", i, o_valid[i], o_ovf[i]);
      end
      if (o_cnt[i] !== 8'd0 || o_addr[i] !== 32'd0) begin
        n_fail++; $display("FAIL reset_log inst%0d: got cnt %0d addr %h want 0", i, o_cnt[i], o_addr[i]);
      end
      if (o_irq[i] !== 1'b0) begin n_fail++; $display("FAIL reset_irq inst%0d: got %b want 0", i, o_irq[i]); end
    end
    hresetn = 1'b1;
  endtask

  task automatic test_single_error();
    irq_en = 1'b0;
    bq.push_back(mk(2'b10, 32'h4000_1000, 1'b0, 4'd2, 1'b0));
    run_burst(0);
    irq_en = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (o_irq[0] !== 1'b1) begin n_fail++; $display("FAIL irq_enable: got %b want 1", o_irq[0]); end
    if (o_addr[0] !== 32'h4000_1000 || o_master[0] !== 4'd2) begin
      n_fail++; $display("FAIL single_capture: got %h/%0d want 40001000/2", o_addr[0], o_master[0]);
    end
  endtask

  task automatic test_back_to_back();
    bq.push_back(mk(2'b10, 32'h0000_0800, 1'b1, 4'd1, 1'b0));
    bq.push_back(mk(2'b10, 32'h0000_0804, 1'b0, 4'd3, 1'b0));
    run_burst(1);
  endtask

  task automatic test_okay_mode();
    bq.push_back(mk(2'b10, 32'h2000_0010, 1'b0, 4'd5, 1'b0));
    bq.push_back(mk(2'b11, 32'h2000_0014, 1'b0, 4'd5, 1'b0));
    run_burst(2);
  endtask

  task automatic test_overflow();
    bq.push_back(mk(2'b00, 32'h0, 1'b0, 4'd0, 1'b1));
    bq.push_back(mk(2'b10, 32'h100, 1'b0, 4'd1, 1'b0));
    bq.push_back(mk(2'b10, 32'h200, 1'b1, 4'd1, 1'b0));
    bq.push_back(mk(2'b10, 32'h300, 1'b0, 4'd1, 1'b0));
    run_burst(0);
    @(negedge clk);
    n_cmp++;
    if (o_addr[0] !== 32'h100 || o_ovf[0] !== 1'b1 || o_cnt[0] !== 8'd3) begin
      n_fail++; $display("FAIL overflow: got %h/%b/%0d want 100/1/3", o_addr[0], o_ovf[0], o_cnt[0]);
    end
  endtask

  task automatic test_saturate();
    bq.push_back(mk(2'b00, 32'h0, 1'b0, 4'd0, 1'b1));
    for (int k = 1; k <= 5; k++) bq.push_back(mk(2'b10, 32'(k * 32'h100), 1'b0, 4'd7, 1'b0));
    run_burst(1);
    @(negedge clk);
    n_cmp++;
    if (o_cnt[1] !== 8'd3) begin n_fail++; $display("FAIL saturate: got %0d want 3", o_cnt[1]); end
    bq.push_back(mk(2'b10, 32'h600, 1'b1, 4'd4, 1'b1));
    run_burst(1);
    @(negedge clk);
    n_cmp++;
    if (o_cnt[1] !== 8'd1 || o_addr[1] !== 32'h600 || o_ovf[1] !== 1'b0) begin
      n_fail++; $display("FAIL clr_accept: got %0d/%h/%b want 1/600/0", o_cnt[1], o_addr[1], o_ovf[1]);
    end
  endtask

  task automatic test_idle_busy();
    bq.push_back(mk(2'b00, 32'hDEAD_0000, 1'b1, 4'd9, 1'b0));
    bq.push_back(mk(2'b01, 32'hDEAD_0004, 1'b0, 4'd9, 1'b0));
    bq.push_back(mk(2'b01, 32'hDEAD_0008, 1'b1, 4'd9, 1'b0));
    run_burst(0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      irq_en = 1'($urandom_range(0, 1));
      for (int k = 0; k < 12; k++) bq.push_back(rand_xfer());
      run_burst(r % NI);
    end
  endtask

  task automatic test_reset_mid();
    irq_en = 1'b1;
    @(posedge clk); #1;
    sel = 0;
    drive(mk(2'b10, 32'h0000_0abc, 1'b0, 4'd1, 1'b0));
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (o_rdy[0] !== 1'b0 || o_rsp[0] !== 1'b1) begin
      n_fail++; $display("FAIL err1_before_reset: got %b%b want 01", o_rdy[0], o_rsp[0]);
    end
    #2 hresetn = 1'b0;
    #1;
    model_reset();
    n_cmp += 3;
    if (o_rdy[0] !== 1'b1 || o_rsp[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_bus: got %b%b want 10", o_rdy[0], o_rsp[0]);
    end
    if (o_valid[0] !== 1'b0 || o_cnt[0] !== 8'd0 || o_addr[0] !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_log: got %b/%0d/%h want 0/0/0", o_valid[0], o_cnt[0], o_addr[0]);
    end
    if (o_irq[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mid_irq: got %b want 0", o_irq[0]); end
    @(negedge clk);
    hresetn = 1'b1;
    bq.push_back(mk(2'b10, 32'h0000_0def, 1'b1, 4'd6, 1'b0));
    run_burst(0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single_error();
    test_back_to_back();
    test_okay_mode();
    test_overflow();
    test_saturate();
    test_idle_busy();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
